i2c_codec_responder: RTL and testbench

- I2C write-only target (responder) that models the codec's control port. It sits on the same SCL/SDA bus that the configuration sender drives.
- Decodes 3-byte write transactions: device address byte, then {reg_addr[6:0], data[8]}, then data[7:0]. ACKs each accepted byte by pulling SDA low.
- Presents each completed register write as a one-cycle strobe.
- Used as an on-chip loopback target and as the bus-level checker for the initialization sequence.

---
 rtl/i2c_codec_responder.sv | 182 ++++++++++++++++++
 tb/tb_i2c_codec_responder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_codec_responder.sv
// I2C write-only target modelling the codec control port.
// Accepts 3-byte writes (device address, {reg_addr, data[8]}, data[7:0]),
// ACKs each accepted byte and emits a one-cycle strobe per completed write.
module i2c_codec_responder #(
  parameter logic [6:0] DEV_ADDR    = 7'b0011010,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_scl,
  inout  wire        io_sda,
  output logic       o_reg_valid,
  output logic [6:0] o_reg_addr,
  output logic [8:0] o_reg_data,
  output logic       o_busy,
  output logic [7:0] o_write_count
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, IGNORE
  } state_t;

  // Input synchronizers plus one edge-detect stage; idle bus level is high.
  logic [SYNC_STAGES-1:0] scl_sync_reg, sda_sync_reg;
  logic                   scl_prev_reg, sda_prev_reg;

  logic scl_s, sda_s;
  logic start_cond, stop_cond, scl_rise, scl_fall;

  // FSM and datapath registers
  state_t      state_reg, state_next;
  logic [2:0]  bit_cnt_reg, bit_cnt_next;
  logic        byte_full_reg, byte_full_next;
  logic [7:0]  shift_reg, shift_next;
  logic [6:0]  addr_tmp_reg, addr_tmp_next;
  logic        d8_tmp_reg, d8_tmp_next;
  logic        sda_low_reg, sda_low_next;
  logic        busy_reg, busy_next;
  logic        reg_valid_reg, reg_valid_next;
  logic [6:0]  reg_addr_reg, reg_addr_next;
  logic [8:0]  reg_data_reg, reg_data_next;
  logic [7:0]  write_count_reg, write_count_next;

  // Shift the raw pins through the synchronizer chain and the edge-detect flop.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      scl_sync_reg <= '1;
      sda_sync_reg <= '1;
      scl_prev_reg <= 1'b1;
      sda_prev_reg <= 1'b1;
    end else begin
      scl_sync_reg <= {scl_sync_reg[SYNC_STAGES-2:0], i_scl};
      sda_sync_reg <= {sda_sync_reg[SYNC_STAGES-2:0], io_sda};
      scl_prev_reg <= scl_sync_reg[SYNC_STAGES-1];
      sda_prev_reg <= sda_sync_reg[SYNC_STAGES-1];
    end
  end

  assign scl_s      = scl_sync_reg[SYNC_STAGES-1];
  assign sda_s      = sda_sync_reg[SYNC_STAGES-1];
  assign start_cond = scl_s & scl_prev_reg & sda_prev_reg & ~sda_s;
  assign stop_cond  = scl_s & scl_prev_reg & ~sda_prev_reg & sda_s;
  assign scl_rise   = scl_s & ~scl_prev_reg;
  assign scl_fall   = ~scl_s & scl_prev_reg;

  // State register for the FSM and its datapath.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg       <= IDLE;
      bit_cnt_reg     <= 3'd0;
      byte_full_reg   <= 1'b0;
      shift_reg       <= 8'd0;
      addr_tmp_reg    <= 7'd0;
      d8_tmp_reg      <= 1'b0;
      sda_low_reg     <= 1'b0;
      busy_reg        <= 1'b0;
      reg_valid_reg   <= 1'b0;
      reg_addr_reg    <= 7'd0;
      reg_data_reg    <= 9'd0;
      write_count_reg <= 8'd0;
    end else begin
      state_reg       <= state_next;
      bit_cnt_reg     <= bit_cnt_next;
      byte_full_reg   <= byte_full_next;
      shift_reg       <= shift_next;
      addr_tmp_reg    <= addr_tmp_next;
      d8_tmp_reg      <= d8_tmp_next;
      sda_low_reg     <= sda_low_next;
      busy_reg        <= busy_next;
      reg_valid_reg   <= reg_valid_next;
      reg_addr_reg    <= reg_addr_next;
      reg_data_reg    <= reg_data_next;
      write_count_reg <= write_count_next;
    end
  end

  // Next-state logic: bus conditions first, then per-state bit/ACK handling.
  always_comb begin
    state_next       = state_reg;
    bit_cnt_next     = bit_cnt_reg;
    byte_full_next   = byte_full_reg;
    shift_next       = shift_reg;
    addr_tmp_next    = addr_tmp_reg;
    d8_tmp_next      = d8_tmp_reg;
    sda_low_next     = sda_low_reg;
    busy_next        = busy_reg;
    reg_valid_next   = 1'b0;
    reg_addr_next    = reg_addr_reg;
    reg_data_next    = reg_data_reg;
    write_count_next = write_count_reg;

    if (stop_cond) begin
      state_next     = IDLE;
      busy_next      = 1'b0;
      sda_low_next   = 1'b0;
      bit_cnt_next   = 3'd0;
      byte_full_next = 1'b0;
    end else if (start_cond) begin
      // Fresh or repeated START: anything partially received is dropped.
      state_next     = ADDR;
      busy_next      = 1'b1;
      sda_low_next   = 1'b0;
      bit_cnt_next   = 3'd0;
      byte_full_next = 1'b0;
      shift_next     = 8'd0;
    end else begin
      case (state_reg)
        ADDR, BYTE1, BYTE2: begin
          if (scl_rise && !byte_full_reg) begin
            shift_next   = {shift_reg[6:0], sda_s};
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) byte_full_next = 1'b1;
          end else if (scl_fall && byte_full_reg) begin
            // Falling edge that ends bit 8: decide and start the ACK window.
            byte_full_next = 1'b0;
            if (state_reg == ADDR) begin
              if (shift_reg[7:1] == DEV_ADDR && !shift_reg[0]) begin
                state_next   = ACK_A;
                sda_low_next = 1'b1;
              end else begin
                state_next = IGNORE;
              end
            end else if (state_reg == BYTE1) begin
              addr_tmp_next = shift_reg[7:1];
              d8_tmp_next   = shift_reg[0];
              state_next    = ACK_1;
              sda_low_next  = 1'b1;
            end else begin
              reg_addr_next    = addr_tmp_reg;
              reg_data_next    = {d8_tmp_reg, shift_reg};
              reg_valid_next   = 1'b1;
              write_count_next = write_count_reg + 8'd1;
              state_next       = ACK_2;
              sda_low_next     = 1'b1;
            end
          end
        end
        ACK_A, ACK_1, ACK_2: begin
          // Falling edge that ends clock 9 closes the ACK window.
          if (scl_fall) begin
            sda_low_next = 1'b0;
            case (state_reg)
              ACK_A:   state_next = BYTE1;
              ACK_1:   state_next = BYTE2;
              default: state_next = IGNORE;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  // Open-drain drive; reset releases the line without waiting for a clock.
  assign io_sda        = (sda_low_reg && !i_rst) ? 1'b0 : 1'bz;
  assign o_reg_valid   = reg_valid_reg;
  assign o_reg_addr    = reg_addr_reg;
  assign o_reg_data    = reg_data_reg;
  assign o_busy        = busy_reg;
  assign o_write_count = write_count_reg;

endmodule

// File: tb/tb_i2c_codec_responder.sv
// Directed bench for i2c_codec_responder: an I2C master drives the bus,
// samples SDA during each SCL high phase and checks ACKs, strobes and counters.
// SCL runs at 40 i_clk cycles per bit so the whole run stays short.
module tb_i2c_codec_responder;

  localparam int Q = 10;  // quarter of an SCL bit period, in i_clk cycles

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       scl = 1'b1;
  logic       sda_low = 1'b0;
  wire        sda_bus;
  logic       o_reg_valid;
  logic [6:0] o_reg_addr;
  logic [8:0] o_reg_data;
  logic       o_busy;
  logic [7:0] o_write_count;

  int checks = 0;
  int errors = 0;
  int n_strobe = 0;
  int base;
  logic [6:0] cap_addr [0:31];
  logic [8:0] cap_data [0:31];

  logic [7:0] init_b1 [0:9] = '{8'h00, 8'h02, 8'h04, 8'h06, 8'h08, 8'h0A, 8'h0C, 8'h0E, 8'h10, 8'h12};
  logic [7:0] init_b2 [0:9] = '{8'h97, 8'h97, 8'h79, 8'h79, 8'h12, 8'h06, 8'h00, 8'h01, 8'h02, 8'h01};

  assign sda_bus = sda_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  always #10 i_clk = ~i_clk;

  i2c_codec_responder dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_scl        (scl),
    .io_sda       (sda_bus),
    .o_reg_valid  (o_reg_valid),
    .o_reg_addr   (o_reg_addr),
    .o_reg_data   (o_reg_data),
    .o_busy       (o_busy),
    .o_write_count(o_write_count)
  );

  // Record every cycle the strobe is high together with the presented write.
  always @(negedge i_clk) begin
    if (o_reg_valid === 1'b1) begin
      if (n_strobe < 32) begin
        cap_addr[n_strobe] = o_reg_addr;
        cap_data[n_strobe] = o_reg_data;
      end
      n_strobe = n_strobe + 1;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wt(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic i2c_start();
    if (scl == 1'b0) begin
      sda_low = 1'b0; wt(Q);
      scl = 1'b1;     wt(Q);
    end
    sda_low = 1'b1; wt(2*Q);
    scl = 1'b0;     wt(Q);
  endtask

  task automatic i2c_stop();
    sda_low = 1'b1; wt(Q);
    scl = 1'b1;     wt(Q);
    sda_low = 1'b0; wt(2*Q);
  endtask

  task automatic send_bit(input logic b, output logic smp);
    sda_low = !b; wt(Q);
    scl = 1'b1;   wt(Q);
    smp = sda_bus; wt(Q);
    scl = 1'b0;   wt(Q);
  endtask

  task automatic send_byte(input logic [7:0] v, input logic exp_ack, input string tag);
    logic smp;
    for (int i = 7; i >= 0; i--) begin
      send_bit(v[i], smp);
      check($sformatf("%s bit%0d", tag, i), {31'd0, smp}, {31'd0, v[i]});
    end
    send_bit(1'b1, smp);
    check({tag, " ack"}, {31'd0, smp}, exp_ack ? 32'd0 : 32'd1);
  endtask

  initial begin
    logic smp;
    // Reset state
    wt(5);
    check("rst sda", {31'd0, sda_bus}, 32'd1);
    i_rst = 1'b0;
    wt(5);
    check("rst valid", {31'd0, o_reg_valid}, 32'd0);
    check("rst addr", {25'd0, o_reg_addr}, 32'd0);
    check("rst data", {23'd0, o_reg_data}, 32'd0);
    check("rst busy", {31'd0, o_busy}, 32'd0);
    check("rst count", {24'd0, o_write_count}, 32'd0);

    // Single write 0x34 0x00 0x97
    i2c_start();
    check("sw busy", {31'd0, o_busy}, 32'd1);
    send_byte(8'h34, 1'b1, "sw dev");
    send_byte(8'h00, 1'b1, "sw b1");
    send_byte(8'h97, 1'b1, "sw b2");
    i2c_stop();
    check("sw busy after stop", {31'd0, o_busy}, 32'd0);
    check("sw idle sda", {31'd0, sda_bus}, 32'd1);
    check("sw strobes", n_strobe, 32'd1);
    check("sw addr", {25'd0, cap_addr[0]}, 32'h0);
    check("sw data", {23'd0, cap_data[0]}, 32'h097);
    check("sw count", {24'd0, o_write_count}, 32'd1);

    // Address mismatch, then read request: both NACKed, no strobe
    i2c_start();
    send_byte(8'h36, 1'b0, "mm dev");
    send_byte(8'h00, 1'b0, "mm b1");
    send_byte(8'h97, 1'b0, "mm b2");
    i2c_stop();
    i2c_start();
    send_byte(8'h35, 1'b0, "rd dev");
    send_byte(8'h00, 1'b0, "rd b1");
    i2c_stop();
    check("mm strobes", n_strobe, 32'd1);
    check("mm count", {24'd0, o_write_count}, 32'd1);

    // Aborted after byte 1
    i2c_start();
    send_byte(8'h34, 1'b1, "ab dev");
    send_byte(8'h08, 1'b1, "ab b1");
    i2c_stop();
    check("ab strobes", n_strobe, 32'd1);
    check("ab addr kept", {25'd0, o_reg_addr}, 32'h0);
    check("ab data kept", {23'd0, o_reg_data}, 32'h097);
    check("ab count", {24'd0, o_write_count}, 32'd1);
    check("ab busy", {31'd0, o_busy}, 32'd0);

    // Repeated START discards the first, partial write
    i2c_start();
    send_byte(8'h34, 1'b1, "rs dev0");
    send_byte(8'h0E, 1'b1, "rs b1a");
    i2c_start();
    check("rs busy", {31'd0, o_busy}, 32'd1);
    send_byte(8'h34, 1'b1, "rs dev1");
    send_byte(8'h10, 1'b1, "rs b1");
    send_byte(8'h01, 1'b1, "rs b2");
    i2c_stop();
    check("rs strobes", n_strobe, 32'd2);
    check("rs addr", {25'd0, cap_addr[1]}, 32'd8);
    check("rs data", {23'd0, cap_data[1]}, 32'h001);
    check("rs count", {24'd0, o_write_count}, 32'd2);

    // Full codec init sequence: ten writes in order
    base = n_strobe;
    for (int k = 0; k < 10; k++) begin
      i2c_start();
      send_byte(8'h34, 1'b1, $sformatf("init%0d dev", k));
      send_byte(init_b1[k], 1'b1, $sformatf("init%0d b1", k));
      send_byte(init_b2[k], 1'b1, $sformatf("init%0d b2", k));
      i2c_stop();
    end
    check("init strobes", n_strobe, base + 10);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("init%0d addr", k), {25'd0, cap_addr[base+k]}, {25'd0, init_b1[k][7:1]});
      check($sformatf("init%0d data", k), {23'd0, cap_data[base+k]}, {23'd0, init_b1[k][0], init_b2[k]});
    end
    check("init final addr", {25'd0, o_reg_addr}, 32'd9);
    check("init final data", {23'd0, o_reg_data}, 32'h001);
    check("init count", {24'd0, o_write_count}, 32'd12);

    // Reset while the device-address ACK is being driven
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(8'h34 >> i, smp);
    sda_low = 1'b0;
    wt(2);
    check("rr ack driven", {31'd0, sda_bus}, 32'd0);
    #3 i_rst = 1'b1;
    #1 check("rr sda released", {31'd0, sda_bus}, 32'd1);
    wt(2);
    check("rr valid", {31'd0, o_reg_valid}, 32'd0);
    check("rr addr", {25'd0, o_reg_addr}, 32'd0);
    check("rr data", {23'd0, o_reg_data}, 32'd0);
    check("rr busy", {31'd0, o_busy}, 32'd0);
    check("rr count", {24'd0, o_write_count}, 32'd0);
    scl = 1'b1;
    wt(Q);
    i_rst = 1'b0;
    wt(Q);
    base = n_strobe;
    i2c_start();
    send_byte(8'h34, 1'b1, "ar dev");
    send_byte(8'h12, 1'b1, "ar b1");
    send_byte(8'h01, 1'b1, "ar b2");
    i2c_stop();
    check("ar strobes", n_strobe, base + 1);
    check("ar addr", {25'd0, o_reg_addr}, 32'd9);
    check("ar data", {23'd0, o_reg_data}, 32'h001);
    check("ar count", {24'd0, o_write_count}, 32'd1);
    check("ar busy", {31'd0, o_busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
